// File: rtl/ondra_tape_in.sv
// ondra_tape_in
//
// Cassette (MGF) line-in conditioner feeding the Ondra core's MGF_IN bit.
// Tracks the DC midpoint of raw ADC samples, slices the signal with a
// hysteresis comparator, and rejects glitches with a consecutive-sample
// stability filter before driving a clean registered tape level.
// It also measures half-period length and reports tape activity.
//
// Ports:
//   clk_sys       system clock
//   reset_n       asynchronous active-low reset
//   adc_data      unsigned ADC sample, qualified by adc_valid
//   adc_valid     one-cycle sample strobe
//   invert        polarity swap applied to the comparator result
//   mgf_in        conditioned tape level
//   edge_stb      one-cycle pulse when mgf_in toggles
//   period        samples between the last two toggles (saturating)
//   period_valid  one-cycle pulse when period updates
//   activity      tape signal present
//   mid           current DC midpoint estimate
//
// Pipeline: stage 1 (cycle carrying adc_valid) registers the sample and the
// pre-update midpoint, and advances the DC tracker. Stage 2 (next cycle)
// runs comparator, filter, half-period counter and activity FSM.

module ondra_tape_in #(
    parameter int ADC_W        = 12,
    parameter int HYST         = 64,
    parameter int FILT         = 4,
    parameter int AVG_SHIFT    = 8,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             invert,
    output logic             mgf_in,
    output logic             edge_stb,
    output logic [15:0]      period,
    output logic             period_valid,
    output logic             activity,
    output logic [ADC_W-1:0] mid
);

    localparam int ACC_W = ADC_W + AVG_SHIFT;
    localparam int CMP_W = ADC_W + 2;

    // midscale << AVG_SHIFT == 2^(ADC_W-1+AVG_SHIFT)
    localparam logic [ACC_W-1:0] ACC_RST  = ACC_W'(1) << (ACC_W - 1);
    localparam logic [ADC_W-1:0] MID_RST  = ADC_W'(1) << (ADC_W - 1);
    localparam logic [CMP_W-1:0] HYST_C   = CMP_W'(HYST);
    localparam logic [3:0]       FILT_C   = 4'(FILT);
    localparam logic [15:0]      IDLE_C   = 16'(IDLE_TIMEOUT);

    typedef enum logic {
        QUIET  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Stage 1 state
    logic [ACC_W-1:0] acc;
    logic [ADC_W-1:0] samp_q;
    logic [ADC_W-1:0] mid_q;
    logic             s2_valid;

    // Stage 2 state
    logic             cmp_raw;
    logic [3:0]       stab_cnt;
    logic [15:0]      hp_cnt;
    state_t           state;

    // Combinational helpers
    logic [ACC_W-1:0] acc_next;
    logic [CMP_W-1:0] samp_x;
    logic [CMP_W-1:0] mid_x;
    logic             cmp_next;
    logic             cmp_eff;
    logic [3:0]       stab_inc;
    logic             toggle;
    logic [15:0]      hp_inc;

    assign mid      = acc[ACC_W-1:AVG_SHIFT];
    assign activity = (state == ACTIVE);

    // The result always fits in ACC_W bits, so modular arithmetic is exact.
    assign acc_next = acc + ACC_W'(adc_data) - ACC_W'(mid);

    always_comb begin
        samp_x   = CMP_W'(samp_q);
        mid_x    = CMP_W'(mid_q);
        cmp_next = cmp_raw;
        if (samp_x >= mid_x + HYST_C) begin
            cmp_next = 1'b1;
        end else if (samp_x + HYST_C <= mid_x) begin
            cmp_next = 1'b0;
        end
        // The held comparator value is kept pre-inversion, so an invert
        // change must still pass through the filter before mgf_in moves.
        cmp_eff  = cmp_next ^ invert;
        stab_inc = stab_cnt + 4'd1;
        toggle   = (cmp_eff != mgf_in) && (stab_inc == FILT_C);
        hp_inc   = (hp_cnt == '1) ? hp_cnt : hp_cnt + 16'd1;
    end

    // Stage 1: sample capture and DC tracker
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= ACC_RST;
            samp_q   <= '0;
            mid_q    <= MID_RST;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= adc_valid;
            if (adc_valid) begin
                samp_q <= adc_data;
                mid_q  <= mid;
                acc    <= acc_next;
            end
        end
    end

    // Stage 2: comparator, filter, half-period counter and activity FSM
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cmp_raw      <= 1'b0;
            stab_cnt     <= '0;
            hp_cnt       <= '0;
            mgf_in       <= 1'b0;
            edge_stb     <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            state        <= QUIET;
        end else begin
            edge_stb     <= 1'b0;
            period_valid <= 1'b0;
            if (s2_valid) begin
                cmp_raw <= cmp_next;

                if (cmp_eff != mgf_in) begin
                    stab_cnt <= toggle ? 4'd0 : stab_inc;
                end else begin
                    stab_cnt <= '0;
                end

                if (toggle) begin
                    mgf_in   <= ~mgf_in;
                    edge_stb <= 1'b1;
                    hp_cnt   <= 16'd1;
                    // A toggle on the timeout sample keeps the FSM active.
                    if (state == ACTIVE) begin
                        period       <= hp_cnt;
                        period_valid <= 1'b1;
                    end
                    state <= ACTIVE;
                end else begin
                    hp_cnt <= hp_inc;
                    if (state == ACTIVE && hp_inc == IDLE_C) begin
                        state <= QUIET;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ondra_tape_in.sv
module tb_ondra_tape_in;

    localparam int ADC_W     = 12;
    localparam int HYST      = 64;
    localparam int FILT      = 4;
    localparam int AVG_SHIFT = 8;
    localparam int IDLE      = 256;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        invert = 1'b0;
    logic        mgf_in;
    logic        edge_stb;
    logic [15:0] period;
    logic        period_valid;
    logic        activity;
    logic [11:0] mid;

    always #5 clk_sys = ~clk_sys;

    ondra_tape_in #(
        .ADC_W        (ADC_W),
        .HYST         (HYST),
        .FILT         (FILT),
        .AVG_SHIFT    (AVG_SHIFT),
        .IDLE_TIMEOUT (IDLE)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .invert       (invert),
        .mgf_in       (mgf_in),
        .edge_stb     (edge_stb),
        .period       (period),
        .period_valid (period_valid),
        .activity     (activity),
        .mid          (mid)
    );

    typedef struct packed {
        logic        mgf;
        logic        edge_s;
        logic        pv;
        logic        act;
        logic [15:0] period;
        logic [11:0] mid;
    } outs_t;

    localparam outs_t RST_OUTS = '{mgf: 1'b0, edge_s: 1'b0, pv: 1'b0, act: 1'b0,
                                   period: 16'd0, mid: 12'd2048};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural reference model ----------------
    // Works per accepted sample with plain integers: a running sample index,
    // the index of the last output edge, and a run length of disagreeing
    // comparator decisions.
    int m_acc, m_raw, m_run, m_level, m_act, m_period, m_idx, m_last_edge;

    function automatic void model_reset();
        m_acc       = 2048 * (1 << AVG_SHIFT);
        m_raw       = 0;
        m_run       = 0;
        m_level     = 0;
        m_act       = 0;
        m_period    = 0;
        m_idx       = 0;
        m_last_edge = 0;
    endfunction

    function automatic outs_t model_step(int s, int inv);
        outs_t e;
        int    m_old;
        int    decided;
        bit    tog;
        bit    pv;
        m_old = m_acc / (1 << AVG_SHIFT);
        m_acc = m_acc + s - m_old;
        if (s >= m_old + HYST)      m_raw = 1;
        else if (s + HYST <= m_old) m_raw = 0;
        decided = m_raw ^ inv;
        tog = 1'b0;
        pv  = 1'b0;
        if (decided != m_level) m_run = m_run + 1;
        else                    m_run = 0;
        if (m_run == FILT) begin
            tog   = 1'b1;
            m_run = 0;
        end
        if (tog) begin
            m_level = 1 - m_level;
            if (m_act != 0) begin
                m_period = (m_idx - m_last_edge > 65535) ? 65535 : (m_idx - m_last_edge);
                pv = 1'b1;
            end
            m_act       = 1;
            m_last_edge = m_idx;
        end else if (m_act != 0 && (m_idx - m_last_edge + 1) == IDLE) begin
            m_act = 0;
        end
        m_idx = m_idx + 1;
        e.mgf    = m_level[0];
        e.edge_s = tog;
        e.pv     = pv;
        e.act    = m_act[0];
        e.period = 16'(m_period);
        e.mid    = 12'(m_acc / (1 << AVG_SHIFT));
        return e;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    function automatic outs_t grab();
        outs_t o;
        o.mgf    = mgf_in;
        o.edge_s = edge_stb;
        o.pv     = period_valid;
        o.act    = activity;
        o.period = period;
        o.mid    = mid;
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("mgf=%0d edge=%0d pv=%0d act=%0d period=%0d mid=%0d",
                         o.mgf, o.edge_s, o.pv, o.act, o.period, o.mid);
    endfunction

    // Called at a negedge; returns at a negedge. Observes the stage-2 result
    // of this sample and flags any pulse seen in the remaining idle clocks.
    task automatic send(input int s, input int gap, output outs_t obs, output bit extra);
        adc_data  = 12'(s);
        adc_valid = 1'b1;
        @(negedge clk_sys);
        adc_valid = 1'b0;
        @(negedge clk_sys);
        obs   = grab();
        extra = 1'b0;
        repeat (gap - 2) begin
            @(negedge clk_sys);
            extra = extra | edge_stb | period_valid;
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        adc_valid = 1'b0;
        invert    = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        outs_t obs;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        obs = grab();
        n_checks++;
        if (obs !== RST_OUTS) begin
            n_fail++;
            $display("FAIL reset_hold: got %s, want %s", fmt(obs), fmt(RST_OUTS));
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            obs = grab();
            n_checks++;
            if (obs !== RST_OUTS) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %s, want %s", i, fmt(obs), fmt(RST_OUTS));
            end
        end
    endtask

    task automatic test_square();
        outs_t obs, exp;
        bit    extra;
        int    idx = 0;
        int    first_rise = -1;
        int    n_pv = 0;
        apply_reset();
        for (int h = 0; h < 6; h++) begin
            for (int k = 0; k < 20; k++) begin
                int s = (h % 2 == 0) ? 2448 : 1648;
                exp = model_step(s, invert);
                send(s, 8, obs, extra);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL square[%0d]: got %s, want %s", idx, fmt(obs), fmt(exp));
                end
                n_checks++;
                if (extra !== 1'b0) begin
                    n_fail++;
                    $display("FAIL square_pulse_width[%0d]: extra pulse=%0d, want 0", idx, extra);
                end
                if (obs.edge_s && first_rise < 0) first_rise = idx;
                if (obs.pv) begin
                    n_pv++;
                    n_checks++;
                    if (obs.period !== 16'd20) begin
                        n_fail++;
                        $display("FAIL square_period[%0d]: got %0d, want 20", idx, obs.period);
                    end
                end
                idx++;
            end
        end
        n_checks++;
        if (first_rise != FILT - 1) begin
            n_fail++;
            $display("FAIL square_first_rise: got sample %0d, want %0d", first_rise, FILT - 1);
        end
        n_checks++;
        if (n_pv != 5) begin
            n_fail++;
            $display("FAIL square_pv_count: got %0d, want 5", n_pv);
        end
    endtask

    task automatic test_glitch();
        outs_t obs, exp;
        bit    extra;
        int    n_edges = 0;
        apply_reset();
        for (int i = 0; i < 223; i++) begin
            int s = (i >= 200 && i < 203) ? 2600 : 1500;
            exp = model_step(s, invert);
            send(s, 2, obs, extra);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL glitch[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
            end
            if (obs.edge_s) n_edges++;
        end
        n_checks++;
        if (n_edges != 0 || mgf_in !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: edges=%0d mgf=%0d, want edges=0 mgf=0", n_edges, mgf_in);
        end
        n_checks++;
        if (m_run != 0) begin
            n_fail++;
            $display("FAIL glitch_model_run: got %0d, want 0", m_run);
        end
    endtask

    task automatic test_back_to_back();
        outs_t q[$];
        outs_t obs, exp;
        int    n = 1000;
        int    n_edges = 0;
        apply_reset();
        for (int j = 0; j < n + 2; j++) begin
            if (j >= 2) begin
                obs = grab();
                exp = q.pop_front();
                obs.mid = '0;
                exp.mid = '0;
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got %s, want %s", j - 2, fmt(obs), fmt(exp));
                end
                if (obs.edge_s) n_edges++;
            end
            if (j < n) begin
                int s = (j % 2 == 0) ? 2100 : 2000;
                q.push_back(model_step(s, invert));
                adc_data  = 12'(s);
                adc_valid = 1'b1;
            end else begin
                adc_valid = 1'b0;
            end
            @(negedge clk_sys);
        end
        n_checks++;
        if (n_edges != 0 || mgf_in !== 1'b0) begin
            n_fail++;
            $display("FAIL hysteresis_hold: edges=%0d mgf=%0d, want edges=0 mgf=0", n_edges, mgf_in);
        end
        n_checks++;
        if (mid !== 12'(m_acc / (1 << AVG_SHIFT))) begin
            n_fail++;
            $display("FAIL b2b_mid: got %0d, want %0d", mid, m_acc / (1 << AVG_SHIFT));
        end
    endtask

    task automatic test_timeout();
        outs_t obs, exp;
        bit    extra;
        int    idx = 0;
        int    last_edge = -1;
        int    drop = -1;
        bit    prev_act = 1'b0;
        int    resume_edges = 0;
        apply_reset();
        // 4 half-periods, then a long constant high level, then 3 more halves
        for (int ph = 0; ph < 3; ph++) begin
            int n_samp = (ph == 0) ? 80 : (ph == 1) ? 300 : 60;
            for (int k = 0; k < n_samp; k++) begin
                int s;
                if (ph == 0)      s = ((k / 20) % 2 == 0) ? 2448 : 1648;
                else if (ph == 1) s = 2448;
                else              s = ((k / 20) % 2 == 0) ? 1648 : 2448;
                exp = model_step(s, invert);
                send(s, 2, obs, extra);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL timeout[%0d]: got %s, want %s", idx, fmt(obs), fmt(exp));
                end
                if (ph < 2) begin
                    if (obs.edge_s) last_edge = idx;
                    if (prev_act && !obs.act && drop < 0) drop = idx;
                    prev_act = obs.act;
                end else if (obs.edge_s) begin
                    resume_edges++;
                    n_checks++;
                    if (obs.pv !== ((resume_edges == 1) ? 1'b0 : 1'b1)) begin
                        n_fail++;
                        $display("FAIL timeout_resume_pv[edge %0d]: got %0d, want %0d",
                                 resume_edges, obs.pv, (resume_edges == 1) ? 0 : 1);
                    end
                end
                idx++;
            end
        end
        n_checks++;
        if (drop - last_edge != IDLE - 1) begin
            n_fail++;
            $display("FAIL timeout_drop: drop=%0d last_edge=%0d, want distance %0d",
                     drop, last_edge, IDLE - 1);
        end
        n_checks++;
        if (resume_edges < 2) begin
            n_fail++;
            $display("FAIL timeout_resume_edges: got %0d, want >=2", resume_edges);
        end
    endtask

    task automatic test_rail_polarity();
        outs_t obs, exp;
        bit    extra;
        int    inv_edge = -1;
        apply_reset();
        // Long run at the top rail pushes mid close to full scale.
        for (int i = 0; i < 1000; i++) begin
            exp = model_step(4095, invert);
            send(4095, 2, obs, extra);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rail_high[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
            end
        end
        for (int i = 0; i < 24; i++) begin
            int s = ((i / 6) % 2 == 0) ? 0 : 4095;
            exp = model_step(s, invert);
            send(s, 3, obs, extra);
            n_checks++;
            if (obs !== exp || extra !== 1'b0) begin
                n_fail++;
                $display("FAIL rail_alt[%0d]: got %s extra=%0d, want %s extra=0",
                         i, fmt(obs), extra, fmt(exp));
            end
        end
        invert = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = model_step(4095, invert);
            send(4095, 3, obs, extra);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL polarity[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
            end
            if (obs.edge_s && inv_edge < 0) inv_edge = i;
        end
        n_checks++;
        if (inv_edge != FILT - 1) begin
            n_fail++;
            $display("FAIL polarity_delay: edge at sample %0d, want %0d", inv_edge, FILT - 1);
        end
        // Drive a few more samples so activity and mid are away from reset values.
        for (int i = 0; i < 3; i++) begin
            exp = model_step(0, invert);
            send(0, 3, obs, extra);
        end
        n_checks++;
        if (activity !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_activity: got %0d, want 1", activity);
        end
        // Asynchronous reset in the middle of a sample transfer.
        adc_data  = 12'd4095;
        adc_valid = 1'b1;
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1 obs = grab();
        n_checks++;
        if (obs !== RST_OUTS) begin
            n_fail++;
            $display("FAIL async_reset: got %s, want %s", fmt(obs), fmt(RST_OUTS));
        end
        @(negedge clk_sys);
        adc_valid = 1'b0;
        invert    = 1'b0;
        reset_n   = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            exp = model_step(4095, invert);
            send(4095, 2, obs, extra);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %s, want %s", i, fmt(obs), fmt(exp));
            end
        end
    endtask

    task automatic test_random();
        outs_t obs, exp;
        bit    extra;
        int    idx = 0;
        apply_reset();
        for (int h = 0; h < 60; h++) begin
            int len  = $urandom_range(2, 24);
            int base = (h % 2 == 0) ? 2448 : 1648;
            for (int k = 0; k < len; k++) begin
                int s   = base + $urandom_range(0, 160) - 80;
                int gap = $urandom_range(2, 5);
                if ($urandom_range(0, 15) == 0) s = $urandom_range(0, 4095);
                if ($urandom_range(0, 199) == 0) invert = ~invert;
                exp = model_step(s, invert);
                send(s, gap, obs, extra);
                n_checks++;
                if (obs !== exp || extra !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got %s extra=%0d, want %s extra=0",
                             idx, fmt(obs), extra, fmt(exp));
                end
                idx++;
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk_sys);
        test_reset();
        test_square();
        test_glitch();
        test_back_to_back();
        test_timeout();
        test_rail_polarity();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
